whiteboard_cell_controller: RTL and testbench

- Owns the single-port 80x60 cell framebuffer: 4800 one-bit cells, 1 = black ink, 0 = white.
- Arbitrates that port between the VGA display read path and the drawing writes.
- Holds and moves the cursor from debounced button pulses, queues draw/erase writes, and sequences full-screen clears.
- Drives the framebuffer address, write enable and write data.
- Writes are confined to blanking intervals, so display reads are never disturbed.

---
 rtl/whiteboard_cell_controller.sv | 173 +++++++++++++++++
 tb/tb_whiteboard_cell_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/whiteboard_cell_controller.sv
// Cursor, write buffering and clear sequencing for the 80x60 one-bit whiteboard framebuffer.
// Framebuffer writes happen only while the display is blanked, so display reads are never disturbed.
module whiteboard_cell_controller #(
  parameter int COLS    = 80,
  parameter int ROWS    = 60,
  parameter int CELLS   = COLS * ROWS,
  parameter int ADDR_W  = 13,
  parameter int START_X = 40,
  parameter int START_Y = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              pen_down,
  input  logic              erase,
  input  logic              clear_req,
  input  logic              display_active,
  input  logic [6:0]        vga_cell_x,
  input  logic [5:0]        vga_cell_y,
  output logic [6:0]        cursor_x,
  output logic [5:0]        cursor_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_wdata,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [6:0]        x_nxt;
  logic [5:0]        y_nxt;
  logic              pen_q;
  logic              moved;
  logic              capture;
  logic              write_pending;
  logic              clear_pending;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_data;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [ADDR_W-1:0] vga_addr;
  logic              blank;
  logic              commit;
  logic              drop;
  logic              clr_last;

  // y*80 + x built from shifts: y*64 + y*16 + x.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [6:0] x, input logic [5:0] y);
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 6) + (yy << 4) + ADDR_W'(x);
  endfunction

  // Up beats down and left beats right; clamped at the board edges.
  always_comb begin
    x_nxt = cursor_x;
    y_nxt = cursor_y;
    if (btn_left) begin
      if (cursor_x != 7'd0) x_nxt = cursor_x - 7'd1;
    end else if (btn_right) begin
      if (cursor_x != 7'(COLS - 1)) x_nxt = cursor_x + 7'd1;
    end
    if (btn_up) begin
      if (cursor_y != 6'd0) y_nxt = cursor_y - 6'd1;
    end else if (btn_down) begin
      if (cursor_y != 6'(ROWS - 1)) y_nxt = cursor_y + 6'd1;
    end
  end

  assign moved    = (x_nxt != cursor_x) || (y_nxt != cursor_y);
  assign capture  = pen_down && (moved || !pen_q);
  assign cap_addr = cell_addr(x_nxt, y_nxt);
  assign vga_addr = cell_addr(vga_cell_x, vga_cell_y);
  assign blank    = !display_active;
  assign commit   = (state == WRITE) && blank;
  assign drop     = (state == IDLE) && blank && clear_pending;
  assign clr_last = (state == CLEAR) && blank && (clr_cnt == ADDR_W'(CELLS - 1));
  assign busy     = clear_pending || (state == CLEAR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (blank) begin
          if (clear_pending)      state_nxt = CLEAR;
          else if (write_pending) state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (blank) state_nxt = IDLE;
      end
      CLEAR: begin
        // A clear request on the final sweep cycle restarts the sweep instead of ending it.
        if (clr_last && !clear_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = vga_addr;
    mem_we    = 1'b0;
    mem_wdata = 1'b0;
    if (blank) begin
      case (state)
        WRITE: begin
          mem_addr  = pend_addr;
          mem_we    = 1'b1;
          mem_wdata = pend_data;
        end
        CLEAR: begin
          mem_addr = clr_cnt;
          mem_we   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cursor_x      <= 7'(START_X);
      cursor_y      <= 6'(START_Y);
      pen_q         <= 1'b0;
      write_pending <= 1'b0;
      clear_pending <= 1'b1;
      pend_addr     <= '0;
      pend_data     <= 1'b0;
      clr_cnt       <= '0;
      overrun       <= 1'b0;
    end else begin
      cursor_x <= x_nxt;
      cursor_y <= y_nxt;
      pen_q    <= pen_down;

      // A capture in the commit cycle becomes the next entry rather than being lost.
      if (capture) begin
        write_pending <= 1'b1;
        pend_addr     <= cap_addr;
        pend_data     <= ~erase;
      end else if (commit || drop) begin
        write_pending <= 1'b0;
      end

      if (capture && write_pending && !commit && !drop) overrun <= 1'b1;

      if (drop)                                 clear_pending <= 1'b0;
      else if (clear_req && (state != CLEAR))   clear_pending <= 1'b1;

      if (state == CLEAR) begin
        if (clear_req)     clr_cnt <= '0;
        else if (clr_last) clr_cnt <= '0;
        else if (blank)    clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_whiteboard_cell_controller.sv
// Randomized bench for whiteboard_cell_controller against a cursor/ink reference model.
// Framebuffer writes are logged at the falling edge and compared with the model's expected writes.
module tb_whiteboard_cell_controller;
  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int CELLS = 4800;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        pen_down = 1'b0, erase = 1'b0, clear_req = 1'b0, display_active = 1'b0;
  logic [6:0]  vga_cell_x = 7'd0;
  logic [5:0]  vga_cell_y = 6'd0;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic [12:0] mem_addr;
  logic        mem_we, mem_wdata, busy, overrun;

  whiteboard_cell_controller dut (
    .clk(clk), .reset_n(reset_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .pen_down(pen_down), .erase(erase), .clear_req(clear_req),
    .display_active(display_active), .vga_cell_x(vga_cell_x), .vga_cell_y(vga_cell_y),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .busy(busy), .overrun(overrun)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;
  logic [13:0] wr_log[$];
  logic [13:0] exp_q[$];

  // Model state: cursor, last pen level, and whether a captured write is stuck behind active video.
  int m_x = 40, m_y = 30;
  bit m_pen = 0, m_blocked = 0, m_pend = 0;

  always @(negedge clk) begin
    if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
    if (mem_we && display_active) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input bit up, input bit dn, input bit lf, input bit rt,
                       input bit pen, input bit ers);
    int nx, ny;
    logic [13:0] e;
    @(posedge clk); #1;
    btn_up = up; btn_down = dn; btn_left = lf; btn_right = rt;
    pen_down = pen; erase = ers;
    nx = m_x; ny = m_y;
    if (lf)      nx = (m_x > 0) ? m_x - 1 : 0;
    else if (rt) nx = (m_x < COLS - 1) ? m_x + 1 : m_x;
    if (up)      ny = (m_y > 0) ? m_y - 1 : 0;
    else if (dn) ny = (m_y < ROWS - 1) ? m_y + 1 : m_y;
    if (pen && (nx != m_x || ny != m_y || !m_pen)) begin
      e = {13'(ny * COLS + nx), ~ers};
      if (m_blocked && m_pend) exp_q[exp_q.size() - 1] = e;
      else                     exp_q.push_back(e);
      m_pend = m_blocked;
    end
    m_x = nx; m_y = ny; m_pen = pen;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, pen_down, erase);
  endtask

  task automatic set_da(input bit v);
    @(posedge clk); #1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    display_active = v;
    m_blocked = v;
    if (!v) m_pend = 0;
  endtask

  task automatic goto_cell(input int x, input int y);
    while (m_x < x) drive(0, 0, 0, 1, 0, erase);
    while (m_x > x) drive(0, 0, 1, 0, 0, erase);
    while (m_y < y) drive(0, 1, 0, 0, 0, erase);
    while (m_y > y) drive(1, 0, 0, 0, 0, erase);
    idle(1);
  endtask

  task automatic flush(input string tag);
    idle(5);
    check({tag, "_count"}, wr_log.size(), exp_q.size());
    while (wr_log.size() > 0 && exp_q.size() > 0) check(tag, wr_log.pop_front(), exp_q.pop_front());
    wr_log.delete();
    exp_q.delete();
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_x"}, cursor_x, m_x);
    check({tag, "_y"}, cursor_y, m_y);
  endtask

  // Log entries from 'start' on must be exactly addresses 0..CELLS-1 with data 0.
  task automatic check_sweep(input string tag, input int start);
    int errs;
    errs = 0;
    check({tag, "_count"}, wr_log.size(), start + CELLS);
    for (int i = 0; i < CELLS && start + i < wr_log.size(); i++)
      if (wr_log[start + i] !== {13'(i), 1'b0}) errs++;
    check({tag, "_seq"}, errs, 0);
    wr_log.delete();
  endtask

  task automatic wait_not_busy(input string tag, input int limit);
    int cyc;
    cyc = 0;
    while (busy && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, busy, 0);
    #1;
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pre;
    int c;
    logic [3:0] b;
    bit pen, ers;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_we", mem_we, 0);
    check("rst_overrun", overrun, 0);
    check_cursor("rst_cursor");
    @(posedge clk); #1;
    reset_n = 1'b1;

    wait_not_busy("boot_clear", 6000);
    check_sweep("boot_sweep", 0);
    check_cursor("boot_cursor");

    drive(0, 0, 0, 0, 1, 0);
    flush("pen_rise");
    drive(0, 0, 0, 1, 1, 0);
    idle(3);
    check("right_latency", wr_log.size(), 1);
    flush("right_wr");
    check_cursor("right_cursor");

    drive(0, 0, 0, 0, 0, 0);
    goto_cell(0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    idle(1);
    check_cursor("corner_cursor");
    drive(0, 0, 0, 0, 1, 0);
    flush("corner_wr");
    drive(1, 0, 1, 0, 1, 0);
    flush("corner_nomove");
    check_cursor("corner_hold");

    drive(0, 0, 0, 0, 0, 0);
    goto_cell(5, 5);
    drive(1, 1, 0, 0, 0, 0);
    idle(1);
    check_cursor("up_wins");
    drive(0, 0, 1, 1, 0, 0);
    idle(1);
    check_cursor("left_wins");

    goto_cell(78, 58);
    for (int i = 0; i < 80; i++) begin
      if (i == 40) begin
        drive(0, 0, 0, 0, 0, 0);
        goto_cell(1, 1);
      end
      b   = 4'($urandom_range(0, 15));
      pen = ($urandom_range(0, 3) != 0);
      ers = ($urandom_range(0, 3) == 0);
      drive(b[3], b[2], b[1], b[0], pen, ers);
      idle(4);
      if (i % 8 == 0) check_cursor("rand_cursor");
    end
    flush("rand_wr");
    check("rand_overrun", overrun, 0);

    drive(0, 0, 0, 0, 0, 0);
    goto_cell(20, 20);
    vga_cell_x = 7'd3;
    vga_cell_y = 6'd2;
    set_da(1);
    drive(0, 0, 0, 1, 1, 0);
    idle(5);
    @(negedge clk);
    check("active_we", mem_we, 0);
    check("active_addr", mem_addr, 163);
    check("active_nowrite", wr_log.size(), 0);
    set_da(0);
    idle(3);
    check("blank_latency", wr_log.size(), 1);
    flush("blank_wr");

    drive(0, 0, 0, 0, 0, 0);
    goto_cell(9, 10);
    set_da(1);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    idle(2);
    drive(0, 0, 0, 1, 1, 0);
    idle(3);
    set_da(0);
    flush("overrun_wr");
    check("overrun_set", overrun, 1);

    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    @(negedge clk);
    check("clr_busy", busy, 1);
    c = 0;
    while (busy && c < 20000) begin
      @(posedge clk); #1;
      display_active = ((c % 160) < 100);
      @(negedge clk);
      c++;
    end
    check("toggle_clear_done", busy, 0);
    @(posedge clk); #1;
    display_active = 1'b0;
    check_sweep("toggle_sweep", 0);
    check("overrun_sticky", overrun, 1);

    @(posedge clk); #1;
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    clear_req = 1'b1;
    @(negedge clk); #1;
    pre = wr_log.size();
    @(posedge clk); #1;
    clear_req = 1'b0;
    check("restart_pre", (pre > 150 && pre < 250) ? 1 : 0, 1);
    wait_not_busy("restart_clear", 6000);
    for (int i = 0; i < pre && i < wr_log.size(); i++)
      if (wr_log[i] !== {13'(i), 1'b0}) viol++;
    check_sweep("restart_sweep", pre);

    check("no_we_in_active", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
